uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmitter at the far end of the debug interface's byte-transmit handshake. The debug interface presents a byte with a one-cycle o_tx_start strobe and waits for a done pulse. This block latches that byte and serializes it on the TX pin as: start bit, LSB-first data, optional parity, stop. It contains its own baud divider and oversample counter, so frame timing is exact in clock cycles. The block sits between the debug interface (o_tx_start/o_data) and the board TX pin, and returns i_txDone to the interface.

Parameters:
NB_DATA, 8, data bits per frame
NB_STOP, 16, stop-bit duration in oversample ticks (16 = 1 stop bit at 16x)
OVERSAMPLE, 16, ticks per start/data/parity bit
BAUD_DIV, 326, clk cycles per tick (100 MHz / (19200*16)); must be >= 1
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  in  1  system clock
i_rst  in  1  reset: asynchronous, active-high
i_tx_start  in  1  start request, sampled only in IDLE
i_data  in  NB_DATA  byte to send, latched on the accept cycle
o_tx  out  1  serial line, idle high
o_txDone  out  1  one-cycle pulse at end of frame
o_busy  out  1  high from accept until the o_txDone cycle (exclusive)

Behaviour:
- Reset (async, any state): o_tx=1, o_txDone=0, o_busy=0, state=IDLE, all counters=0, shift register=0. A frame in progress is abandoned with no done pulse. The first accept is possible on the first edge after i_rst deasserts.
- Outputs are registered. States: IDLE, START, DATA, PARITY, STOP.
- Tick generator: counter 0..BAUD_DIV-1 produces a tick when it wraps. It is cleared on accept, so every bit boundary is cycle-exact relative to the accept edge.
- IDLE: o_tx=1. On an edge with i_tx_start=1, accept:
  - latch i_data into the shift register; compute the parity bit (even: XOR of data; odd: its inverse)
  - move to START; o_busy=1 and o_tx=0 from this edge
  - i_tx_start while not IDLE is ignored; no queueing
- START: held for OVERSAMPLE ticks, then DATA with bit 0 on o_tx.
- DATA: each bit held OVERSAMPLE ticks, LSB first, for NB_DATA bits. Bit index counter is ceil(log2(NB_DATA+1)) wide. After the last bit go to PARITY (if PARITY!=0, o_tx=parity bit, OVERSAMPLE ticks) or to STOP.
- STOP: o_tx=1 for NB_STOP ticks. On the final tick: state=IDLE, o_busy=0, o_txDone=1 for exactly one cycle.
- Frame length in clocks = ((1 + NB_DATA + (PARITY!=0)) * OVERSAMPLE + NB_STOP) * BAUD_DIV. The accept edge to the o_txDone edge is exactly this value.
- Back-to-back: i_tx_start on the o_txDone cycle is accepted, since the state is already IDLE. o_tx goes 1→0 with no extra idle cycles.
- i_data changes after accept have no effect on the frame in progress.
- PARITY values 3 and above behave as 0.

Test Plan:
- Reset: assert i_rst mid-cycle with no clock edge → o_tx=1, o_busy=0, o_txDone=0 immediately.
- Single frame, BAUD_DIV=4, PARITY=0, byte 0xA5 → o_tx goes low at accept; every 64 clocks o_tx steps through 1,0,1,0,0,1,0,1 (LSB first); stop is high for 64 clocks; o_txDone pulses once exactly 640 clocks after accept; o_busy high for 640 cycles.
- Parity: PARITY=1 with 0x03 → parity bit 0; PARITY=2 with 0x03 → parity bit 1; frame length 704 clocks with BAUD_DIV=4; o_txDone at cycle 704.
- Ignored start / latched data: while busy, pulse i_tx_start with i_data=0xFF → the current frame is unchanged and no second frame is sent.
- Back-to-back: raise i_tx_start on the o_txDone cycle with 0x3C → the next start bit begins on that edge and the gap between frames is 0 cycles.
- Reset mid-frame: assert i_rst during DATA bit 4 → o_tx=1 at once and no o_txDone. After release, sending 0x5A produces a complete 640-clock frame.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// Byte-transmit handshake between the debug interface and the UART serializer.
//   i_tx_start : one-cycle start request from the debug side
//   i_data     : byte to send, sampled by the serializer on its accept cycle
//   o_tx       : serial line towards the board pin (idle high)
//   o_txDone   : one-cycle end-of-frame pulse back to the debug side
//   o_busy     : frame in flight (accept cycle through the cycle before o_txDone)
// master = debug-interface side, slave = serializer side.
interface uart_tx_serializer_if #(
   parameter int NB_DATA = 8
);
   logic               i_tx_start;
   logic [NB_DATA-1:0] i_data;
   logic               o_tx;
   logic               o_txDone;
   logic               o_busy;

   modport master (
      output i_tx_start,
      output i_data,
      input  o_tx,
      input  o_txDone,
      input  o_busy
   );

   modport slave (
      input  i_tx_start,
      input  i_data,
      output o_tx,
      output o_txDone,
      output o_busy
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a byte on the accept cycle and sends
// start bit, LSB-first data, optional parity bit and stop on o_tx.
// Frame timing is exact in clk cycles: the baud divider restarts on accept.
//   clk   : system clock
//   i_rst : asynchronous, active-high reset
//   bus   : slave side of uart_tx_serializer_if (start/data in, tx/done/busy out)
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | line high, waiting for i_tx_start
// S_START  | start bit (low) for OVERSAMPLE ticks
// S_DATA   | data bits LSB first, OVERSAMPLE ticks each
// S_PARITY | parity bit for OVERSAMPLE ticks (only when enabled)
// S_STOP   | line high for NB_STOP ticks, then done pulse
module uart_tx_serializer #(
   parameter int NB_DATA    = 8,
   parameter int NB_STOP    = 16,
   parameter int OVERSAMPLE = 16,
   parameter int BAUD_DIV   = 326,
   parameter int PARITY     = 0
) (
   input  logic                 clk,
   input  logic                 i_rst,
   uart_tx_serializer_if.slave  bus
);

   localparam int  BAUD_W = $clog2(BAUD_DIV + 1);
   localparam int  OS_MAX = (OVERSAMPLE > NB_STOP) ? OVERSAMPLE : NB_STOP;
   localparam int  OS_W   = $clog2(OS_MAX + 1);
   localparam int  BIT_W  = $clog2(NB_DATA + 1);
   // Only 1 (even) and 2 (odd) add a parity bit; anything else sends none.
   localparam bit  PAR_EN  = (PARITY == 1) || (PARITY == 2);
   localparam bit  PAR_ODD = (PARITY == 2);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [OS_W-1:0]   BIT_TLAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]   STOP_LAST = OS_W'(NB_STOP - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(NB_DATA - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [OS_W-1:0]     os_q, os_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [NB_DATA-1:0]  shreg_q, shreg_d;
   logic                par_q, par_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                tick;
   logic                bit_end;
   logic                stop_end;
   logic [NB_DATA-1:0]  shreg_shift;

   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      os_d        = os_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      tx_d        = tx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      shreg_shift = shreg_q >> 1;

      tick     = (baud_q == BAUD_LAST);
      bit_end  = tick && (os_q == BIT_TLAST);
      stop_end = tick && (os_q == STOP_LAST);

      // Divider and oversample counter only run while a frame is in flight;
      // in IDLE they sit at zero so the accept edge is the timing origin.
      if (state_q != S_IDLE) begin
         baud_d = tick ? '0 : baud_q + BAUD_W'(1);
         if (tick) begin
            os_d = os_q + OS_W'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (bus.i_tx_start) begin
               state_d = S_START;
               baud_d  = '0;
               os_d    = '0;
               bit_d   = '0;
               shreg_d = bus.i_data;
               par_d   = PAR_ODD ? ~^bus.i_data : ^bus.i_data;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               os_d    = '0;
               tx_d    = shreg_q[0];
            end
         end

         S_DATA: begin
            if (bit_end) begin
               os_d = '0;
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
                  if (PAR_EN) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shreg_d = shreg_shift;
                  tx_d    = shreg_shift[0];
               end
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               os_d    = '0;
               tx_d    = 1'b1;
            end
         end

         S_STOP: begin
            if (stop_end) begin
               state_d = S_IDLE;
               os_d    = '0;
               baud_d  = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               tx_d    = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         os_q    <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.o_tx     = tx_q;
   assign bus.o_txDone = done_q;
   assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

   localparam int BD = 4;
   localparam int OS = 16;
   localparam int NS = 16;
   localparam int NB = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start [4];
   logic [7:0] data  [4];
   logic       tx    [4];
   logic       done  [4];
   logic       busy  [4];

   int tests = 0;
   int fails = 0;

   uart_tx_serializer_if #(.NB_DATA(NB)) bus0 ();
   uart_tx_serializer_if #(.NB_DATA(NB)) bus1 ();
   uart_tx_serializer_if #(.NB_DATA(NB)) bus2 ();
   uart_tx_serializer_if #(.NB_DATA(NB)) bus3 ();

   assign bus0.i_tx_start = start[0];
   assign bus0.i_data     = data[0];
   assign tx[0]           = bus0.o_tx;
   assign done[0]         = bus0.o_txDone;
   assign busy[0]         = bus0.o_busy;
   assign bus1.i_tx_start = start[1];
   assign bus1.i_data     = data[1];
   assign tx[1]           = bus1.o_tx;
   assign done[1]         = bus1.o_txDone;
   assign busy[1]         = bus1.o_busy;
   assign bus2.i_tx_start = start[2];
   assign bus2.i_data     = data[2];
   assign tx[2]           = bus2.o_tx;
   assign done[2]         = bus2.o_txDone;
   assign busy[2]         = bus2.o_busy;
   assign bus3.i_tx_start = start[3];
   assign bus3.i_data     = data[3];
   assign tx[3]           = bus3.o_tx;
   assign done[3]         = bus3.o_txDone;
   assign busy[3]         = bus3.o_busy;

   // Instance N uses PARITY = N (3 must behave like no parity).
   uart_tx_serializer #(.NB_DATA(NB), .NB_STOP(NS), .OVERSAMPLE(OS), .BAUD_DIV(BD), .PARITY(0))
      dut0 (.clk(clk), .i_rst(rst), .bus(bus0));
   uart_tx_serializer #(.NB_DATA(NB), .NB_STOP(NS), .OVERSAMPLE(OS), .BAUD_DIV(BD), .PARITY(1))
      dut1 (.clk(clk), .i_rst(rst), .bus(bus1));
   uart_tx_serializer #(.NB_DATA(NB), .NB_STOP(NS), .OVERSAMPLE(OS), .BAUD_DIV(BD), .PARITY(2))
      dut2 (.clk(clk), .i_rst(rst), .bus(bus2));
   uart_tx_serializer #(.NB_DATA(NB), .NB_STOP(NS), .OVERSAMPLE(OS), .BAUD_DIV(BD), .PARITY(3))
      dut3 (.clk(clk), .i_rst(rst), .bus(bus3));

   // Reference model: line level k clocks after the accept edge.
   function automatic int n_bits(input int mode);
      return 1 + NB + (((mode == 1) || (mode == 2)) ? 1 : 0);
   endfunction

   function automatic int frame_len(input int mode);
      return (n_bits(mode) * OS + NS) * BD;
   endfunction

   function automatic int seg_of(input int mode, input int k);
      int s;
      s = k / (OS * BD);
      return (s < n_bits(mode)) ? s : n_bits(mode);
   endfunction

   function automatic logic exp_level(input logic [7:0] b, input int mode, input int k);
      int s;
      s = seg_of(mode, k);
      if (s == 0) return 1'b0;
      if (s <= NB) return b[s-1];
      if (s < n_bits(mode)) return (mode == 1) ? (^b) : ~(^b);
      return 1'b1;
   endfunction

   // Entered at a negedge with the DUT idle (or in its done cycle).
   // poke_k >= 0: pulse start with 0xFF during that cycle of the frame.
   // abort_k >= 0: assert reset mid-cycle at that cycle and return.
   task automatic run_frame(input int idx, input logic [7:0] b, input int poke_k, input int abort_k);
      int   len;
      int   bad_k;
      logic bt, bb, bdn, be;
      len = frame_len(idx);
      start[idx] = 1'b1;
      data[idx]  = b;
      @(negedge clk);
      bad_k = -1;
      bt = 1'b0; bb = 1'b0; bdn = 1'b0; be = 1'b0;
      for (int k = 0; k < len; k++) begin
         if (k == 0) begin
            start[idx] = 1'b0;
            data[idx]  = 8'($urandom);
         end
         if (k == abort_k) begin
            #2 rst = 1'b1;
            #1;
            tests++;
            if (tx[idx] !== 1'b1 || busy[idx] !== 1'b0 || done[idx] !== 1'b0) begin
               fails++;
               $display("FAIL reset_mid dut%0d: tx/busy/done=%b%b%b expected 100",
                        idx, tx[idx], busy[idx], done[idx]);
            end
            return;
         end
         if (tx[idx] !== exp_level(b, idx, k) || busy[idx] !== 1'b1 || done[idx] !== 1'b0) begin
            if (bad_k < 0) begin
               bad_k = k; bt = tx[idx]; bb = busy[idx]; bdn = done[idx]; be = exp_level(b, idx, k);
            end
         end
         if (k == poke_k) begin
            start[idx] = 1'b1;
            data[idx]  = 8'hFF;
         end else if (k == poke_k + 1) begin
            start[idx] = 1'b0;
         end
         if ((k + 1 == len) || (seg_of(idx, k + 1) != seg_of(idx, k))) begin
            tests++;
            if (bad_k >= 0) begin
               fails++;
               $display("FAIL frame dut%0d byte %02h seg %0d cycle %0d: tx/busy/done=%b%b%b expected %b10",
                        idx, b, seg_of(idx, k), bad_k, bt, bb, bdn, be);
            end
            bad_k = -1;
         end
         @(negedge clk);
      end
      tests++;
      if (done[idx] !== 1'b1 || busy[idx] !== 1'b0 || tx[idx] !== 1'b1) begin
         fails++;
         $display("FAIL done_cycle dut%0d at %0d clocks: tx/busy/done=%b%b%b expected 101",
                  idx, len, tx[idx], busy[idx], done[idx]);
      end
   endtask

   // Advance n cycles from a done/idle cycle, line must stay idle.
   task automatic idle_check(input int idx, input int n);
      int bad_k;
      bad_k = -1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if ((tx[idx] !== 1'b1 || busy[idx] !== 1'b0 || done[idx] !== 1'b0) && bad_k < 0) bad_k = k;
      end
      tests++;
      if (bad_k >= 0) begin
         fails++;
         $display("FAIL idle dut%0d cycle %0d: tx/busy/done=%b%b%b expected 100",
                  idx, bad_k, tx[idx], busy[idx], done[idx]);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         start[i] = 1'b0;
         data[i]  = 8'h00;
      end
      rst = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
            fails++;
            $display("FAIL reset dut%0d: tx/busy/done=%b%b%b expected 100", i, tx[i], busy[i], done[i]);
         end
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_frame();
      run_frame(0, 8'hA5, -1, -1);
      idle_check(0, 20);
   endtask

   task automatic test_parity();
      run_frame(1, 8'h03, -1, -1);
      idle_check(1, 5);
      run_frame(2, 8'h03, -1, -1);
      idle_check(2, 5);
      run_frame(1, 8'hB6, -1, -1);
      idle_check(1, 5);
      run_frame(2, 8'hB6, -1, -1);
      idle_check(2, 5);
      run_frame(3, 8'h03, -1, -1);
      idle_check(3, 5);
   endtask

   task automatic test_ignored_start();
      run_frame(0, 8'h81, 100, -1);
      idle_check(0, 100);
      run_frame(2, 8'h10, 650, -1);
      idle_check(2, 100);
   endtask

   task automatic test_back_to_back();
      run_frame(0, 8'hC3, -1, -1);
      run_frame(0, 8'h3C, -1, -1);
      idle_check(0, 5);
      run_frame(1, 8'h7E, -1, -1);
      run_frame(1, 8'h01, -1, -1);
      idle_check(1, 5);
   endtask

   task automatic test_reset_mid();
      // Bit 4 occupies clocks 320..383 after accept.
      run_frame(0, 8'hE7, -1, 340);
      repeat (3) begin
         @(negedge clk);
      end
      tests++;
      if (done[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold dut0: tx/busy/done=%b%b%b expected 100", tx[0], busy[0], done[0]);
      end
      rst = 1'b0;
      run_frame(0, 8'h5A, -1, -1);
      idle_check(0, 5);
   endtask

   task automatic test_random();
      int idx;
      int gap;
      for (int n = 0; n < 6; n++) begin
         idx = int'($urandom_range(0, 3));
         gap = int'($urandom_range(0, 4));
         run_frame(idx, 8'($urandom), (($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 600)) : -1), -1);
         if (gap > 0) idle_check(idx, gap);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_parity();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
